// File: rtl/byte_packer.sv
// Packs RATIO input symbols MSB-first into one OUT_W-bit word.
// Define BYTE_PACKER_SINC_EN to enable COM_SYM lock search and loss-of-lock.
module byte_packer #(
    parameter int                IN_W        = 8,
    parameter int                RATIO       = 4,
    parameter logic [IN_W-1:0]   COM_SYM     = IN_W'(8'hBC),
    parameter int                SINC_COUNT  = 4,
    parameter int                LOSS_CYCLES = 8
) (
    input  logic                    clk_f,
    input  logic                    reset,
    input  logic [IN_W-1:0]         data_in,
    input  logic                    valid_in,
    output logic [IN_W*RATIO-1:0]   data_out,
    output logic                    valid_out,
    output logic                    sinc
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [OUT_W-1:0]     partial_q, partial_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OUT_W-1:0]     data_out_q, data_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 sinc_q, sinc_d;
    logic [OUT_W-1:0]     shifted_word;
    logic                 last_beat;

    // Shifting left keeps the first beat of a word in the MSBs.
    assign shifted_word = {partial_q[OUT_W-IN_W-1:0], data_in};
    assign last_beat    = (idx_q == IDX_W'(RATIO - 1));

`ifdef BYTE_PACKER_SINC_EN
    localparam int          SYNC_W   = $clog2(SINC_COUNT) + 1;
    localparam int          INV_W    = $clog2(LOSS_CYCLES) + 1;
    localparam logic [SYNC_W-1:0] SYNC_MAX = '1;
    localparam logic [INV_W-1:0]  INV_MAX  = '1;
    localparam state_t      RESET_STATE = SEARCH;

    logic [SYNC_W-1:0]    sync_cnt_q, sync_cnt_d;
    logic [INV_W-1:0]     inv_cnt_q, inv_cnt_d;

    always_comb begin
        state_d     = state_q;
        partial_d   = partial_q;
        idx_d       = idx_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        sinc_d      = sinc_q;
        sync_cnt_d  = sync_cnt_q;
        inv_cnt_d   = inv_cnt_q;

        case (state_q)
            SEARCH: begin
                sinc_d = 1'b0;
                if (valid_in) begin
                    if (data_in == COM_SYM) begin
                        sync_cnt_d = (sync_cnt_q == SYNC_MAX) ? sync_cnt_q
                                                              : sync_cnt_q + 1'b1;
                        if (sync_cnt_d >= SYNC_W'(SINC_COUNT)) begin
                            state_d   = LOCKED;
                            sinc_d    = 1'b1;
                            idx_d     = '0;
                            partial_d = '0;
                            inv_cnt_d = '0;
                        end
                    end else begin
                        sync_cnt_d = '0;
                    end
                end
            end
            default: begin
                sinc_d = 1'b1;
                if (valid_in) begin
                    inv_cnt_d = '0;
                    if (last_beat) begin
                        data_out_d  = shifted_word;
                        valid_out_d = 1'b1;
                        partial_d   = '0;
                        idx_d       = '0;
                    end else begin
                        partial_d = shifted_word;
                        idx_d     = idx_q + 1'b1;
                    end
                end else begin
                    inv_cnt_d = (inv_cnt_q == INV_MAX) ? inv_cnt_q
                                                       : inv_cnt_q + 1'b1;
                    // Too long without data: drop lock and the partial word.
                    if (inv_cnt_d >= INV_W'(LOSS_CYCLES)) begin
                        state_d    = SEARCH;
                        sinc_d     = 1'b0;
                        partial_d  = '0;
                        idx_d      = '0;
                        sync_cnt_d = '0;
                        inv_cnt_d  = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            sync_cnt_q <= '0;
            inv_cnt_q  <= '0;
        end else begin
            sync_cnt_q <= sync_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
        end
    end
`else
    localparam state_t RESET_STATE = LOCKED;

    logic unused_cfg;
    assign unused_cfg = ^{COM_SYM, SINC_COUNT[0], LOSS_CYCLES[0]};

    always_comb begin
        state_d     = state_q;
        partial_d   = partial_q;
        idx_d       = idx_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        sinc_d      = 1'b1;

        if (valid_in) begin
            if (last_beat) begin
                data_out_d  = shifted_word;
                valid_out_d = 1'b1;
                partial_d   = '0;
                idx_d       = '0;
            end else begin
                partial_d = shifted_word;
                idx_d     = idx_q + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            partial_q   <= '0;
            idx_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            sinc_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            partial_q   <= partial_d;
            idx_q       <= idx_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            sinc_q      <= sinc_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign sinc      = sinc_q;

endmodule
